ln_calc: RTL and testbench

//   Iterative fixed-point natural logarithm, the inverse of the exp block: result = ln(num).

---
 rtl/ln_calc.sv | 121 ++++++++++++
 tb/tb_ln_calc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ln_calc.sv
// ln_calc: iterative fixed-point natural log via m*2^k reduction and a 2*atanh series.
// Define LN_INVALID_FLAG_EN to add the invalid output for num<=0.
module ln_calc #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIXED_PNT    = 8,
  parameter int SERIES_TERMS = 6,
  parameter int GUARD_BITS   = 4
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] num,
  output logic signed [DATA_WIDTH-1:0] ln_num,
  output logic                         data_ready
`ifdef LN_INVALID_FLAG_EN
  ,
  output logic                         invalid
`endif
);
  localparam int IW = DATA_WIDTH + GUARD_BITS + 2;
  localparam int W2 = 2 * IW;
  localparam int F  = FIXED_PNT + GUARD_BITS;
  localparam int MW = $clog2(DATA_WIDTH);
  localparam logic signed [IW-1:0] ONE = IW'(1 << F);
  localparam logic signed [IW-1:0] LN2 = IW'(int'(0.6931471805599453 * 2.0**F));
  localparam logic signed [IW-1:0] HI  = IW'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [IW-1:0] LO  = ~HI;
  localparam logic signed [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, NORM, DIVY, SERIES, COMBINE} state_t;
  state_t state;
  logic enable_d, start;
  logic signed [DATA_WIDTH-1:0] x, out_n;
  logic signed [IW-1:0] k, m, y2, acc, term;
  logic signed [IW-1:0] k_n, m_n, y_n, y2_n, term_n, acc_n, ln_w, ln_q;
  logic [MW-1:0] msb;
  logic [3:0] n;

  assign start = enable & ~enable_d;

  always_comb begin
    msb = '0;
    for (int i = 0; i < DATA_WIDTH; i++) if (x[i]) msb = MW'(i);
  end

  always_comb begin
    k_n    = IW'($signed({1'b0, msb})) - IW'(FIXED_PNT);
    m_n    = (int'(msb) > F) ? IW'(x) >>> (int'(msb) - F) : IW'(x) <<< (F - int'(msb));
    y_n    = IW'((W2'(m - ONE) <<< F) / W2'(m + ONE));
    y2_n   = IW'((W2'(y_n) * W2'(y_n)) >>> F);
    term_n = IW'((W2'(term) * W2'(y2)) >>> F);
    acc_n  = acc + term_n / $signed({{(IW-5){1'b0}}, n, 1'b1});
    ln_w   = k * LN2 + (acc_n <<< 1);
    // bias negatives before the arithmetic shift so truncation goes toward zero
    ln_q   = (ln_w + (ln_w[IW-1] ? IW'((1 << GUARD_BITS) - 1) : IW'(0))) >>> GUARD_BITS;
    out_n  = ln_q > HI ? HI[DATA_WIDTH-1:0] : ln_q < LO ? LO[DATA_WIDTH-1:0] : ln_q[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      enable_d   <= 1'b0;
      ln_num     <= '0;
      data_ready <= 1'b0;
      x          <= '0;
      k          <= '0;
      m          <= '0;
      y2         <= '0;
      acc        <= '0;
      term       <= '0;
      n          <= '0;
    end else begin
      enable_d   <= enable;
      data_ready <= 1'b0;
      if (state != IDLE && !enable) state <= IDLE;
      else case (state)
        IDLE: begin
          if (start && num > 0) begin
            x     <= num;
            state <= NORM;
          end else if (start) begin
            ln_num     <= MIN;
            data_ready <= 1'b1;
          end
        end
        NORM: begin
          k     <= k_n;
          m     <= m_n;
          state <= DIVY;
        end
        DIVY: begin
          acc   <= y_n;
          term  <= y_n;
          y2    <= y2_n;
          n     <= 4'd1;
          state <= (SERIES_TERMS > 2) ? SERIES : COMBINE;
        end
        // the final series term is folded into COMBINE
        SERIES: begin
          term <= term_n;
          acc  <= acc_n;
          n    <= n + 4'd1;
          if (n == 4'(SERIES_TERMS-2)) state <= COMBINE;
        end
        COMBINE: begin
          ln_num     <= out_n;
          data_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LN_INVALID_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) invalid <= 1'b0;
    else if (state == IDLE && start) invalid <= !(num > 0);
  end
`endif
endmodule

// File: tb/tb_ln_calc.sv
// tb_ln_calc: randomized and directed checks of ln_calc against a real-valued ln model.
module tb_ln_calc;
  logic clk = 0, rst = 1, enable = 0;
  logic signed [15:0] num = 0;
  logic signed [15:0] ln_num;
  logic data_ready;
`ifdef LN_INVALID_FLAG_EN
  logic invalid;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ln_calc dut (
    .clk(clk), .rst(rst), .enable(enable), .num(num),
    .ln_num(ln_num), .data_ready(data_ready)
`ifdef LN_INVALID_FLAG_EN
    , .invalid(invalid)
`endif
  );

  function automatic real ideal(input int v);
    return $ln(real'(v) / 256.0) * 256.0;
  endfunction

  task automatic run(input logic signed [15:0] v, output logic signed [15:0] res, output int lat);
    @(negedge clk);
    num = v;
    enable = 1;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (data_ready) begin
        lat = i;
        break;
      end
    end
    res = ln_num;
    @(negedge clk);
    enable = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (ln_num !== 16'h0000 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset: ln_num=%h data_ready=%b, want 0000/0", ln_num, data_ready);
    end
`ifdef LN_INVALID_FLAG_EN
    checks++;
    if (invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_invalid: got %b want 0", invalid);
    end
`endif
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic signed [15:0] vin [5] = '{16'h0100, 16'h0200, 16'h0080, 16'h02B8, 16'h7FFF};
    logic signed [15:0] vexp [5] = '{16'h0000, 16'h00B1, 16'hFF4F, 16'h0100, 16'h04DA};
    logic signed [15:0] res;
    int lat, tol;
    for (int i = 0; i < 5; i++) begin
      run(vin[i], res, lat);
      tol = (i == 0) ? 0 : 2;
      checks++;
      if (int'(res) - int'(vexp[i]) > tol || int'(vexp[i]) - int'(res) > tol) begin
        errors++;
        $display("FAIL directed num=%h: ln_num=%h want %h +/-%0d", vin[i], res, vexp[i], tol);
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL directed_latency num=%h: got %0d want 8", vin[i], lat);
      end
    end
  endtask

  task automatic test_random;
    logic signed [15:0] v, res;
    int lat;
    real d;
    for (int i = 0; i < 24; i++) begin
      v = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 32767));
      run(v, res, lat);
      d = real'(res) - ideal(int'(v));
      checks++;
      if (d > 2.0 || d < -2.0) begin
        errors++;
        $display("FAIL random num=%h: ln_num=%h want %f +/-2", v, res, ideal(int'(v)));
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL random_latency num=%h: got %0d want 8", v, lat);
      end
    end
  endtask

  task automatic test_invalid;
    logic signed [15:0] vin [3];
    logic signed [15:0] res;
    int lat;
    vin[0] = 16'h0000;
    vin[1] = 16'hFF00;
    vin[2] = 16'(-int'($urandom_range(1, 32768)));
    for (int i = 0; i < 3; i++) begin
      run(vin[i], res, lat);
      checks++;
      if (res !== 16'h8000 || lat != 1) begin
        errors++;
        $display("FAIL invalid num=%h: ln_num=%h lat=%0d want 8000 lat=1", vin[i], res, lat);
      end
`ifdef LN_INVALID_FLAG_EN
      checks++;
      if (invalid !== 1'b1) begin
        errors++;
        $display("FAIL invalid_flag num=%h: got %b want 1", vin[i], invalid);
      end
`endif
    end
    run(16'h0100, res, lat);
    checks++;
    if (res !== 16'h0000 || lat != 8) begin
      errors++;
      $display("FAIL after_invalid: ln_num=%h lat=%0d want 0000 lat=8", res, lat);
    end
`ifdef LN_INVALID_FLAG_EN
    checks++;
    if (invalid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_clear: got %b want 0", invalid);
    end
`endif
  endtask

  task automatic test_abort;
    logic signed [15:0] res;
    int lat, seen;
    real d;
    run(16'h0000, res, lat);
    @(negedge clk);
    num = 16'h0300;
    enable = 1;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1 seen |= int'(data_ready);
    end
    @(negedge clk);
    enable = 0;
    repeat (12) begin
      @(posedge clk);
      #1 seen |= int'(data_ready);
    end
    checks++;
    if (seen != 0 || ln_num !== 16'h8000) begin
      errors++;
      $display("FAIL abort: data_ready_seen=%0d ln_num=%h want 0/8000", seen, ln_num);
    end
    run(16'h0300, res, lat);
    d = real'(res) - ideal(768);
    checks++;
    if (lat != 8 || d > 2.0 || d < -2.0) begin
      errors++;
      $display("FAIL abort_restart: ln_num=%h lat=%0d want %f lat=8", res, lat, ideal(768));
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    num = 16'h0300;
    enable = 1;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (ln_num !== 16'h0000 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ln_num=%h data_ready=%b want 0000/0", ln_num, data_ready);
    end
    enable = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int pulses, first;
    real d;
    @(negedge clk);
    num = 16'h02B8;
    enable = 1;
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (data_ready) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    d = real'(ln_num) - 256.0;
    checks++;
    if (pulses != 1 || first != 8) begin
      errors++;
      $display("FAIL back_to_back: pulses=%0d first=%0d want 1/8", pulses, first);
    end
    checks++;
    if (d > 2.0 || d < -2.0) begin
      errors++;
      $display("FAIL back_to_back_value: ln_num=%h want 0100 +/-2", ln_num);
    end
    @(negedge clk);
    enable = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_invalid();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
